fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
Parametrised forwarding and hazard controller for the pipelined core, the next generation of the EX-stage forwarding unit. It generates per-port ALU forwarding selects for NPORT source operands with configurable register-address width. It adds load-use stall detection with a multicycle load-latency FSM, flush abort, optional WB-to-ID bypass flags and a saturating stall-cycle counter. It sits beside the ID/EX pipeline register and drives the operand muxes, the PC/IFID write-enable and the ID/EX bubble insertion.

Parameters:
AW, 4, register address width; address 0 is the hardwired zero register.
NPORT, 2, number of source operands per instruction (port i packed at bits [i*AW +: AW]).
LOAD_LAT, 1, total stall cycles per load-use hazard (legal values 1..15).
WB_BYPASS, 1, 1 = generate idBypass flags; 0 = idBypass tied to 0.
CNT_W, 16, width of the stall statistics counter.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous reset, active-high.
IDsrc  in  NPORT*AW  source register addresses of the instruction in IF/ID.
IDsrcVld  in  NPORT  per-port "source actually read" qualifiers.
IDEXsrc  in  NPORT*AW  source addresses of the instruction in ID/EX.
IDEXrd  in  AW  destination of the instruction in ID/EX.
IDEXregWrite  in  1  ID/EX writes a register.
IDEXmemRead  in  1  ID/EX is a load.
EXMEMrd  in  AW  EX/MEM destination.
EXMEMregWrite  in  1  EX/MEM write enable.
MEMWBrd  in  AW  MEM/WB destination.
MEMWBregWrite  in  1  MEM/WB write enable.
flush  in  1  branch/exception flush of IF/ID and ID/EX.
fwdSel  out  NPORT*2  per-port operand select: 2'b10 = EX/MEM, 2'b01 = MEM/WB, 2'b00 = register file.
idBypass  out  NPORT  per-port: the IF/ID source equals a valid MEMWBrd, so the register file must be read write-through.
stall  out  1  hold PC and IF/ID.
bubble  out  1  zero the ID/EX control fields next edge.
stallCnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- The clock and reset are fixed: a single clock, clk; reset rst is synchronous and active-high.
- fwdSel is combinational with zero latency. For each port i:
  - EX/MEM wins when EXMEMregWrite is set, EXMEMrd != 0 and EXMEMrd == IDEXsrc[i].
  - Otherwise MEM/WB is selected under the same conditions using MEMWBrd.
  - Otherwise 2'b00.
  - EX/MEM takes priority when both stages match.
- idBypass[i] is set when WB_BYPASS is 1, IDsrcVld[i] is set, MEMWBregWrite is set, MEMWBrd != 0 and MEMWBrd == IDsrc[i]. It is combinational.
- Hazard detection is combinational: hz is set when IDEXmemRead and IDEXregWrite are both set, IDEXrd != 0, and some port i has IDsrcVld[i] set with IDsrc[i] == IDEXrd.
- The FSM has two states, IDLE and STALL, with a down-counter rem of width 4.
  - IDLE: stall = bubble = hz & ~flush. If hz & ~flush and LOAD_LAT > 1, go to STALL and set rem <= LOAD_LAT-1.
  - STALL: stall = 1 and bubble = 1. Each cycle rem <= rem-1. When rem == 1, return to IDLE.
  - hz is not re-evaluated in STALL.
  - Total stall cycles per hazard is exactly LOAD_LAT, counting the detect cycle.
- flush has priority in any state. stall and bubble read 0 in the same cycle, and next state is IDLE with rem = 0. An in-progress stall is abandoned.
- When hz and flush occur in the same cycle, no stall occurs.
- stallCnt increments on every cycle where stall = 1. It saturates at all-ones and does not wrap.
- Reset (synchronous, including mid-stall):
  - State, rem and stallCnt are registered and go to IDLE, 0 and 0.
  - stall and bubble therefore read 0 in the cycle after the reset edge, provided hz is 0.
  - fwdSel and idBypass are combinational and unaffected.
- A destination of zero never forwards, bypasses or stalls.

Decomposition:
- Package fwd_hazard_pkg holds:
  - the FWD_RF, FWD_MEMWB and FWD_EXMEM 2-bit constants;
  - the state enum IDLE/STALL.
- One sub-module, fwd_port_sel, instantiated NPORT times via generate. It holds the per-port comparator producing fwdSel and idBypass.
- The FSM and the counter stay in the top module.

Test Plan:
1. EXMEMrd=3, regWrite=1, IDEXsrc port0=3; MEMWBrd=3 also valid -> fwdSel[1:0]=2'b10 (EX/MEM priority). Then EXMEMregWrite=0 -> 2'b01.
2. EXMEMrd=0, regWrite=1, IDEXsrc=0 on all ports -> fwdSel all 2'b00, no stall.
3. LOAD_LAT=1: load IDEXrd=5, IDsrc port1=5, IDsrcVld=2'b10 -> stall=bubble=1 for exactly one cycle, stallCnt=1. Same with IDsrcVld=2'b00 -> no stall.
4. LOAD_LAT=3: hazard at cycle t -> stall high at t, t+1 and t+2, low at t+3, stallCnt=3. flush at t+1 -> stall low from t+1, state IDLE.
5. rst asserted at t+1 of a LOAD_LAT=3 stall -> stall=0 and stallCnt=0 from t+2.
6. CNT_W=4: 20 consecutive stall cycles -> stallCnt holds 4'hF. MEMWBrd=7, regWrite=1, IDsrc port0=7, vld=1 -> idBypass[0]=1. With WB_BYPASS=0 -> idBypass=0.

Source files
------------

// File: rtl/fwd_hazard_pkg.sv
// rtl/fwd_hazard_pkg.sv - shared forwarding select codes and hazard FSM states
package fwd_hazard_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } hz_state_t;

endpackage

// File: rtl/fwd_port_sel.sv
// rtl/fwd_port_sel.sv - per-operand forwarding select and WB-to-ID bypass comparator
module fwd_port_sel
  import fwd_hazard_pkg::*;
#(
  parameter int AW        = 4,
  parameter int WB_BYPASS = 1
) (
  input  logic [AW-1:0] i_idex_src,
  input  logic [AW-1:0] i_id_src,
  input  logic          i_id_src_vld,
  input  logic [AW-1:0] i_exmem_rd,
  input  logic          i_exmem_we,
  input  logic [AW-1:0] i_memwb_rd,
  input  logic          i_memwb_we,
  output logic [1:0]    o_fwd_sel,
  output logic          o_id_bypass
);

  logic w_exmem_hit;
  logic w_memwb_hit;
  logic w_wb_id_hit;

  // Register 0 is hardwired zero, so a zero destination never produces a hit.
  assign w_exmem_hit = i_exmem_we && (i_exmem_rd != '0) && (i_exmem_rd == i_idex_src);
  assign w_memwb_hit = i_memwb_we && (i_memwb_rd != '0) && (i_memwb_rd == i_idex_src);
  assign w_wb_id_hit = i_id_src_vld && i_memwb_we && (i_memwb_rd != '0) && (i_memwb_rd == i_id_src);

  always_comb begin
    o_fwd_sel = FWD_RF;
    if (w_exmem_hit) begin
      o_fwd_sel = FWD_EXMEM;
    end else if (w_memwb_hit) begin
      o_fwd_sel = FWD_MEMWB;
    end
  end

  assign o_id_bypass = (WB_BYPASS != 0) && w_wb_id_hit;

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - EX forwarding selects, load-use stall FSM and stall counter
module fwd_hazard_unit
  import fwd_hazard_pkg::*;
#(
  parameter int AW        = 4,
  parameter int NPORT     = 2,
  parameter int LOAD_LAT  = 1,
  parameter int WB_BYPASS = 1,
  parameter int CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NPORT*AW-1:0]   IDsrc,
  input  logic [NPORT-1:0]      IDsrcVld,
  input  logic [NPORT*AW-1:0]   IDEXsrc,
  input  logic [AW-1:0]         IDEXrd,
  input  logic                  IDEXregWrite,
  input  logic                  IDEXmemRead,
  input  logic [AW-1:0]         EXMEMrd,
  input  logic                  EXMEMregWrite,
  input  logic [AW-1:0]         MEMWBrd,
  input  logic                  MEMWBregWrite,
  input  logic                  flush,
  output logic [NPORT*2-1:0]    fwdSel,
  output logic [NPORT-1:0]      idBypass,
  output logic                  stall,
  output logic                  bubble,
  output logic [CNT_W-1:0]      stallCnt
);

  localparam logic [3:0] LAT_M1    = 4'(LOAD_LAT - 1);
  localparam bit         MULTI_LAT = (LOAD_LAT > 1);

  logic [NPORT-1:0] w_port_hz;
  logic             w_hz;
  hz_state_t        r_state;
  hz_state_t        w_next_state;
  logic [3:0]       r_rem;
  logic [3:0]       w_next_rem;
  logic             w_stall;
  logic [CNT_W-1:0] r_cnt;

  for (genvar g = 0; g < NPORT; g++) begin : g_port
    fwd_port_sel #(
      .AW        (AW),
      .WB_BYPASS (WB_BYPASS)
    ) u_sel (
      .i_idex_src   (IDEXsrc[g*AW +: AW]),
      .i_id_src     (IDsrc[g*AW +: AW]),
      .i_id_src_vld (IDsrcVld[g]),
      .i_exmem_rd   (EXMEMrd),
      .i_exmem_we   (EXMEMregWrite),
      .i_memwb_rd   (MEMWBrd),
      .i_memwb_we   (MEMWBregWrite),
      .o_fwd_sel    (fwdSel[g*2 +: 2]),
      .o_id_bypass  (idBypass[g])
    );

    assign w_port_hz[g] = IDsrcVld[g] && (IDsrc[g*AW +: AW] == IDEXrd);
  end

  assign w_hz = IDEXmemRead && IDEXregWrite && (IDEXrd != '0) && (|w_port_hz);

  // The detect cycle is the first stall cycle; STALL covers the remaining LOAD_LAT-1.
  always_comb begin
    w_next_state = r_state;
    w_next_rem   = r_rem;
    w_stall      = 1'b0;
    case (r_state)
      IDLE: begin
        w_stall = w_hz && !flush;
        if (w_stall && MULTI_LAT) begin
          w_next_state = STALL;
          w_next_rem   = LAT_M1;
        end
      end
      STALL: begin
        w_stall    = 1'b1;
        w_next_rem = r_rem - 4'd1;
        if (r_rem == 4'd1) begin
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_rem   = '0;
      end
    endcase
    if (flush) begin
      w_stall      = 1'b0;
      w_next_state = IDLE;
      w_next_rem   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_rem   <= w_next_rem;
      if (w_stall && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign stall    = w_stall;
  assign bubble   = w_stall;
  assign stallCnt = r_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - randomized and directed check of fwd_hazard_unit against a reference model
module tb_fwd_hazard_unit;

  localparam int AW     = 4;
  localparam int NP     = 2;
  localparam int LAT_A  = 3;
  localparam int CNTW_A = 4;
  localparam int LAT_B  = 1;
  localparam int CNTW_B = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP*AW-1:0] IDsrc;
  logic [NP-1:0]    IDsrcVld;
  logic [NP*AW-1:0] IDEXsrc;
  logic [AW-1:0]    IDEXrd;
  logic             IDEXregWrite;
  logic             IDEXmemRead;
  logic [AW-1:0]    EXMEMrd;
  logic             EXMEMregWrite;
  logic [AW-1:0]    MEMWBrd;
  logic             MEMWBregWrite;
  logic             flush;

  logic [NP*2-1:0]   a_fwd, b_fwd;
  logic [NP-1:0]     a_byp, b_byp;
  logic              a_stall, a_bubble, b_stall, b_bubble;
  logic [CNTW_A-1:0] a_cnt;
  logic [CNTW_B-1:0] b_cnt;

  int checks = 0;
  int errors = 0;

  int m_a_left, m_a_cnt, m_b_left, m_b_cnt;

  fwd_hazard_unit #(
    .AW(AW), .NPORT(NP), .LOAD_LAT(LAT_A), .WB_BYPASS(1), .CNT_W(CNTW_A)
  ) u_dut_a (
    .clk(clk), .rst(rst), .IDsrc(IDsrc), .IDsrcVld(IDsrcVld), .IDEXsrc(IDEXsrc),
    .IDEXrd(IDEXrd), .IDEXregWrite(IDEXregWrite), .IDEXmemRead(IDEXmemRead),
    .EXMEMrd(EXMEMrd), .EXMEMregWrite(EXMEMregWrite), .MEMWBrd(MEMWBrd),
    .MEMWBregWrite(MEMWBregWrite), .flush(flush), .fwdSel(a_fwd), .idBypass(a_byp),
    .stall(a_stall), .bubble(a_bubble), .stallCnt(a_cnt)
  );

  fwd_hazard_unit #(
    .AW(AW), .NPORT(NP), .LOAD_LAT(LAT_B), .WB_BYPASS(0), .CNT_W(CNTW_B)
  ) u_dut_b (
    .clk(clk), .rst(rst), .IDsrc(IDsrc), .IDsrcVld(IDsrcVld), .IDEXsrc(IDEXsrc),
    .IDEXrd(IDEXrd), .IDEXregWrite(IDEXregWrite), .IDEXmemRead(IDEXmemRead),
    .EXMEMrd(EXMEMrd), .EXMEMregWrite(EXMEMregWrite), .MEMWBrd(MEMWBrd),
    .MEMWBregWrite(MEMWBregWrite), .flush(flush), .fwdSel(b_fwd), .idBypass(b_byp),
    .stall(b_stall), .bubble(b_bubble), .stallCnt(b_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    rst = 1'b0; IDsrc = '0; IDsrcVld = '0; IDEXsrc = '0; IDEXrd = '0;
    IDEXregWrite = 1'b0; IDEXmemRead = 1'b0; EXMEMrd = '0; EXMEMregWrite = 1'b0;
    MEMWBrd = '0; MEMWBregWrite = 1'b0; flush = 1'b0;
  endtask

  // Inputs are driven after the falling edge; outputs are checked 1ns later and
  // the model then advances to the state it expects after the next rising edge.
  task automatic step();
    logic [NP*2-1:0] e_fwd;
    logic [NP-1:0]   e_byp;
    logic            hz;
    int              e_sa, e_sb;
    #1;
    hz = 1'b0;
    e_fwd = '0;
    e_byp = '0;
    for (int i = 0; i < NP; i++) begin
      logic [AW-1:0] s_ex, s_id;
      s_ex = IDEXsrc[i*AW +: AW];
      s_id = IDsrc[i*AW +: AW];
      if (EXMEMregWrite && EXMEMrd != 0 && EXMEMrd == s_ex) e_fwd[i*2 +: 2] = 2'b10;
      else if (MEMWBregWrite && MEMWBrd != 0 && MEMWBrd == s_ex) e_fwd[i*2 +: 2] = 2'b01;
      if (IDsrcVld[i] && MEMWBregWrite && MEMWBrd != 0 && MEMWBrd == s_id) e_byp[i] = 1'b1;
      if (IDsrcVld[i] && s_id == IDEXrd) hz = 1'b1;
    end
    hz = hz && IDEXmemRead && IDEXregWrite && (IDEXrd != 0);
    e_sa = flush ? 0 : ((m_a_left > 0) ? 1 : int'(hz));
    e_sb = flush ? 0 : ((m_b_left > 0) ? 1 : int'(hz));

    check_val("a_fwdSel",   32'(a_fwd),    32'(e_fwd));
    check_val("b_fwdSel",   32'(b_fwd),    32'(e_fwd));
    check_val("a_idBypass", 32'(a_byp),    32'(e_byp));
    check_val("b_idBypass", 32'(b_byp),    32'd0);
    check_val("a_stall",    32'(a_stall),  32'(e_sa));
    check_val("a_bubble",   32'(a_bubble), 32'(e_sa));
    check_val("b_stall",    32'(b_stall),  32'(e_sb));
    check_val("b_bubble",   32'(b_bubble), 32'(e_sb));
    check_val("a_stallCnt", 32'(a_cnt),    32'(m_a_cnt));
    check_val("b_stallCnt", 32'(b_cnt),    32'(m_b_cnt));

    if (rst) begin
      m_a_left = 0; m_a_cnt = 0;
      m_b_left = 0; m_b_cnt = 0;
    end else begin
      if (e_sa == 1 && m_a_cnt < (1 << CNTW_A) - 1) m_a_cnt++;
      if (e_sb == 1 && m_b_cnt < (1 << CNTW_B) - 1) m_b_cnt++;
      if (flush)             m_a_left = 0;
      else if (m_a_left > 0) m_a_left--;
      else if (hz)           m_a_left = LAT_A - 1;
      if (flush)             m_b_left = 0;
      else if (m_b_left > 0) m_b_left--;
      else if (hz)           m_b_left = LAT_B - 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_hazard(input logic [1:0] vld);
    clear_inputs();
    IDEXrd = 4'd5; IDEXmemRead = 1'b1; IDEXregWrite = 1'b1;
    IDsrc = {4'd5, 4'd2}; IDsrcVld = vld;
  endtask

  initial begin
    m_a_left = 0; m_a_cnt = 0; m_b_left = 0; m_b_cnt = 0;
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    step();
    rst = 1'b0;
    step();

    // EX/MEM priority over MEM/WB, then MEM/WB alone
    EXMEMrd = 4'd3; EXMEMregWrite = 1'b1; MEMWBrd = 4'd3; MEMWBregWrite = 1'b1;
    IDEXsrc = {4'd1, 4'd3};
    step();
    EXMEMregWrite = 1'b0;
    step();

    // zero register never forwards or stalls
    clear_inputs();
    EXMEMregWrite = 1'b1;
    step();
    IDEXmemRead = 1'b1; IDEXregWrite = 1'b1; IDsrcVld = 2'b11;
    step();

    // load-use hazard on port 1, then with sources not read
    load_hazard(2'b10);
    step();
    clear_inputs();
    repeat (3) step();
    load_hazard(2'b00);
    step();

    // full multicycle stall, then one abandoned by flush
    load_hazard(2'b10);
    step();
    clear_inputs();
    repeat (3) step();
    load_hazard(2'b10);
    step();
    clear_inputs();
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (2) step();

    // hazard and flush together
    load_hazard(2'b10);
    flush = 1'b1;
    step();
    clear_inputs();

    // reset in the middle of a stall
    load_hazard(2'b10);
    step();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (2) step();

    // counter saturation with a persistent hazard
    load_hazard(2'b10);
    repeat (20) step();

    // WB-to-ID bypass
    clear_inputs();
    MEMWBrd = 4'd7; MEMWBregWrite = 1'b1; IDsrc = {4'd0, 4'd7}; IDsrcVld = 2'b01;
    step();

    // randomized traffic over a narrow address range to provoke matches
    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(0, 49) == 0);
      flush         = ($urandom_range(0, 9) == 0);
      IDsrc         = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      IDEXsrc       = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
      IDsrcVld      = 2'($urandom_range(0, 3));
      IDEXrd        = 4'($urandom_range(0, 3));
      IDEXregWrite  = 1'($urandom_range(0, 1));
      IDEXmemRead   = 1'($urandom_range(0, 1));
      EXMEMrd       = 4'($urandom_range(0, 3));
      EXMEMregWrite = 1'($urandom_range(0, 1));
      MEMWBrd       = 4'($urandom_range(0, 3));
      MEMWBregWrite = 1'($urandom_range(0, 1));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
